// File: rtl/nios_mul_pkg.sv
// Shared types and elaboration helpers for the iterative Nios II multiply cell.
// Slice count, pair count and counter widths are derived here so top and bench agree.
package nios_mul_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL   = 3'd1,
    DRAIN = 3'd2,
    SIGN  = 3'd3,
    DONE  = 3'd4
  } state_e;

  function automatic int nslices(input int width, input int slice);
    return width / slice;
  endfunction

  // Low-only products skip every pair whose weight lands at or above WIDTH.
  function automatic int num_pairs(input int n, input bit hi_en);
    return hi_en ? n * n : (n * (n + 1)) / 2;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nios_mul_slice.sv
// Registered SLICE x SLICE unsigned multiplier shared by every partial product of the cell.
// One cycle from operands to product; synchronous active-high reset clears the product.
module nios_mul_slice #(
  parameter int SLICE = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SLICE-1:0]   a,
  input  logic [SLICE-1:0]   b,
  output logic [2*SLICE-1:0] p
);

  logic [2*SLICE-1:0] p_d;
  logic [2*SLICE-1:0] p_q;

  always_comb begin
    p_d = (2*SLICE)'(a) * (2*SLICE)'(b);
  end

  always_ff @(posedge clk) begin
    if (reset) p_q <= '0;
    else       p_q <= p_d;
  end

  assign p = p_q;

endmodule

// File: rtl/nios2_mul_iter_cell.sv
// Iterative multiply cell: one slice pair per cycle, result P+2 edges after accept, held until out_ready.
// NIOS_MUL_HI_EN selects the full signed 2*WIDTH product; otherwise only the sign-independent low half.
module nios2_mul_iter_cell
  import nios_mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_a_signed,
  input  logic             in_b_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_lo,
  output logic [WIDTH-1:0] out_hi,
  output logic             busy
);

  if ((WIDTH % SLICE) != 0) begin : g_bad_width
    $error("nios2_mul_iter_cell: WIDTH must be a multiple of SLICE");
  end

`ifdef NIOS_MUL_HI_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  localparam int N     = nslices(WIDTH, SLICE);
  localparam int P     = num_pairs(N, HI_EN);
  localparam int ACC_W = HI_EN ? 2 * WIDTH : WIDTH;
  localparam int CW    = cnt_w(N);
  localparam int SW    = CW + 1;
  localparam int KW    = cnt_w(P);

  state_e             state_q, state_d;
  logic [CW-1:0]      i_q, i_d;
  logic [CW-1:0]      j_q, j_d;
  logic [KW-1:0]      k_q, k_d;
  logic [WIDTH-1:0]   a_mag_q, a_mag_d;
  logic [WIDTH-1:0]   b_mag_q, b_mag_d;
  logic               neg_q, neg_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   res_q, res_d;
  logic               pp_vld_q, pp_vld_d;
  logic [SW-1:0]      pp_shift_q, pp_shift_d;

  logic [WIDTH-1:0]   op_a, op_b;
  logic               op_neg;
  logic [SLICE-1:0]   slice_a, slice_b;
  logic [2*SLICE-1:0] slice_p;
  logic [ACC_W-1:0]   pp_ext;
  logic [ACC_W-1:0]   acc_neg;
  logic [SW-1:0]      sum_ij;
  logic               row_last;
  logic               pair_last;

  // Operand conditioning: magnitudes only matter when the full product is produced.
`ifdef NIOS_MUL_HI_EN
  logic sa, sb;
  always_comb begin
    sa     = in_a_signed & in_a[WIDTH-1];
    sb     = in_b_signed & in_b[WIDTH-1];
    op_a   = sa ? -in_a : in_a;
    op_b   = sb ? -in_b : in_b;
    op_neg = sa ^ sb;
  end
`else
  logic unused_sign;
  assign unused_sign = in_a_signed ^ in_b_signed;
  always_comb begin
    op_a   = in_a;
    op_b   = in_b;
    op_neg = 1'b0;
  end
`endif

  always_comb begin
    slice_a = a_mag_q[i_q*SLICE +: SLICE];
    slice_b = b_mag_q[j_q*SLICE +: SLICE];
  end

  nios_mul_slice #(.SLICE(SLICE)) u_slice (
    .clk   (clk),
    .reset (reset),
    .a     (slice_a),
    .b     (slice_b),
    .p     (slice_p)
  );

  always_comb begin
    sum_ij    = SW'(i_q) + SW'(j_q);
    row_last  = HI_EN ? (j_q == CW'(N - 1)) : (sum_ij == SW'(N - 1));
    pair_last = (k_q == KW'(P - 1));
    pp_ext    = ACC_W'(slice_p) << (pp_shift_q * SLICE);
    acc_neg   = -acc_q;
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    a_mag_d    = a_mag_q;
    b_mag_d    = b_mag_q;
    neg_d      = neg_q;
    acc_d      = acc_q;
    res_d      = res_q;
    pp_vld_d   = 1'b0;
    pp_shift_d = pp_shift_q;

    // The product tagged in the previous cycle lands here, during MUL and DRAIN.
    if (pp_vld_q) acc_d = acc_q + pp_ext;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_mag_d = op_a;
          b_mag_d = op_b;
          neg_d   = op_neg;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        pp_vld_d   = 1'b1;
        pp_shift_d = sum_ij;
        k_d        = k_q + 1'b1;
        if (row_last) begin
          i_d = i_q + 1'b1;
          j_d = '0;
        end else begin
          j_d = j_q + 1'b1;
        end
        if (pair_last) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = SIGN;
      end
      SIGN: begin
        acc_d   = neg_q ? acc_neg : acc_q;
        res_d   = acc_d;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      a_mag_q    <= '0;
      b_mag_q    <= '0;
      neg_q      <= 1'b0;
      acc_q      <= '0;
      res_q      <= '0;
      pp_vld_q   <= 1'b0;
      pp_shift_q <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      a_mag_q    <= a_mag_d;
      b_mag_q    <= b_mag_d;
      neg_q      <= neg_d;
      acc_q      <= acc_d;
      res_q      <= res_d;
      pp_vld_q   <= pp_vld_d;
      pp_shift_q <= pp_shift_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_lo    = res_q[WIDTH-1:0];

`ifdef NIOS_MUL_HI_EN
  assign out_hi = res_q[ACC_W-1:WIDTH];
`else
  assign out_hi = '0;
`endif

endmodule
